// File: rtl/axi_slave_burst_mem.sv
// axi_slave_burst_mem: AXI4 burst memory slave with independent read and write engines.
//   Clock/reset : ACLK (rising edge), ARESETn (asynchronous, active-low)
//   AW/W/B      : write address, write data (byte strobes) and write response channels
//   AR/R        : read address and read data channels (one cycle from handshake to data)
//   Memory      : DEPTH words of DATA_WIDTH bits, word index = ADDR >> log2(DATA_WIDTH/8)
//   Macro       : AXI_SLV_WRAP_EN enables WRAP bursts; without it WRAP is an illegal burst.
// Illegal bursts and out-of-range beats never touch memory and return SLVERR.
module axi_slave_burst_mem #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  // write address
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  // write data
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  // write response
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  // read address
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  // read data
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFFS_W = $clog2(STRB_W);
  localparam int unsigned IDX_W  = ADDR_WIDTH - OFFS_W;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  localparam logic [IDX_W:0] DEPTH_I = (IDX_W+1)'(DEPTH);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

`ifdef AXI_SLV_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // WRAP is legal only for 2/4/8/16-beat bursts; burst type 2'b11 is reserved
  function automatic logic burst_legal(input logic [1:0] burst, input logic [7:0] len);
    logic ok;
    ok = 1'b0;
    case (burst)
      BURST_FIXED, BURST_INCR: ok = 1'b1;
      BURST_WRAP: ok = WRAP_EN && ((len == 8'd1) || (len == 8'd3) ||
                                   (len == 8'd7) || (len == 8'd15));
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Word index of the following beat; WRAP keeps the upper bits and wraps the low LEN bits
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic [7:0]       len,
                                                input logic [1:0]       burst);
    logic [IDX_W-1:0] mask;
    logic [IDX_W-1:0] inc;
    logic [IDX_W-1:0] res;
    mask = IDX_W'(len);
    inc  = idx + IDX_W'(1);
    case (burst)
      BURST_INCR: res = inc;
      BURST_WRAP: res = (idx & ~mask) | (inc & mask);
      default:    res = idx;
    endcase
    return res;
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return {1'b0, idx} < DEPTH_I;
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // ---------------- write engine ----------------
  w_state_e              w_state_q;
  logic                  awready_q, wready_q, bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   aw_id_q;
  logic [IDX_W-1:0]      w_idx_q;
  logic [7:0]            w_len_q, w_cnt_q;
  logic [1:0]            w_burst_q;
  logic                  w_legal_q, w_err_q;

  logic w_beat_c, w_last_beat_c, w_beat_ok_c, w_err_d;

  assign w_beat_c      = WVALID && wready_q;
  assign w_last_beat_c = (w_cnt_q == w_len_q);
  assign w_beat_ok_c   = w_legal_q && in_range(w_idx_q);
  // sticky error including this beat: bad address/burst or WLAST out of step with AWLEN
  assign w_err_d       = w_err_q || !w_beat_ok_c || (WLAST != w_last_beat_c);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_id_q   <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_burst_q <= BURST_FIXED;
      w_legal_q <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (AWVALID && awready_q) begin
            aw_id_q   <= AWID;
            w_idx_q   <= AWADDR[ADDR_WIDTH-1:OFFS_W];
            w_len_q   <= AWLEN;
            w_burst_q <= AWBURST;
            w_legal_q <= burst_legal(AWBURST, AWLEN);
            w_err_q   <= !burst_legal(AWBURST, AWLEN);
            w_cnt_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_beat_c) begin
            w_err_q <= w_err_d;
            if (w_last_beat_c) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= w_err_d ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end else begin
              w_cnt_q <= w_cnt_q + 8'd1;
              w_idx_q <= next_idx(w_idx_q, w_len_q, w_burst_q);
            end
          end
        end
        W_RESP: begin
          if (BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Memory array is deliberately not reset; only strobed lanes of accepted legal beats are written
  always_ff @(posedge ACLK) begin
    if (w_beat_c && w_beat_ok_c) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (WSTRB[k]) mem_q[w_idx_q[MEM_AW-1:0]][8*k +: 8] <= WDATA[8*k +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  r_state_e              r_state_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [IDX_W-1:0]      r_idx_q;
  logic [7:0]            r_len_q, r_cnt_q;
  logic [1:0]            r_burst_q;
  logic                  r_legal_q;

  logic             ar_hs_c, r_hs_c, r_ok_c, r_legal_d;
  logic [IDX_W-1:0] r_idx_d;
  logic [7:0]       r_len_d;
  logic [1:0]       r_burst_d;

  assign ar_hs_c   = ARVALID && arready_q;
  assign r_hs_c    = rvalid_q && RREADY;
  // attributes of the beat about to be loaded: fresh from AR on a handshake, else the live burst
  assign r_idx_d   = ar_hs_c ? ARADDR[ADDR_WIDTH-1:OFFS_W] : r_idx_q;
  assign r_len_d   = ar_hs_c ? ARLEN : r_len_q;
  assign r_burst_d = ar_hs_c ? ARBURST : r_burst_q;
  assign r_legal_d = ar_hs_c ? burst_legal(ARBURST, ARLEN) : r_legal_q;
  assign r_ok_c    = r_legal_d && in_range(r_idx_d);

  // Nonblocking read of mem_q yields pre-write data on a same-cycle same-word collision
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= BURST_FIXED;
      r_legal_q <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs_c) begin
            r_id_q    <= ARID;
            r_len_q   <= ARLEN;
            r_burst_q <= ARBURST;
            r_legal_q <= r_legal_d;
            r_cnt_q   <= '0;
            rdata_q   <= r_ok_c ? mem_q[r_idx_d[MEM_AW-1:0]] : '0;
            rresp_q   <= r_ok_c ? RESP_OKAY : RESP_SLVERR;
            r_idx_q   <= next_idx(r_idx_d, r_len_d, r_burst_d);
            rlast_q   <= (ARLEN == 8'd0);
            rvalid_q  <= 1'b1;
            arready_q <= 1'b0;
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (r_hs_c) begin
            if (r_cnt_q == r_len_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= R_IDLE;
            end else begin
              rdata_q <= r_ok_c ? mem_q[r_idx_d[MEM_AW-1:0]] : '0;
              rresp_q <= r_ok_c ? RESP_OKAY : RESP_SLVERR;
              r_idx_q <= next_idx(r_idx_d, r_len_d, r_burst_d);
              rlast_q <= ((r_cnt_q + 8'd1) == r_len_q);
              r_cnt_q <= r_cnt_q + 8'd1;
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // byte-offset address bits do not select anything
  logic unused_addr_lsb_c;
  assign unused_addr_lsb_c = ^{AWADDR[OFFS_W-1:0], ARADDR[OFFS_W-1:0]};

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign BID     = aw_id_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;
  assign RID     = r_id_q;

endmodule

// File: tb/tb_axi_slave_burst_mem.sv
// Directed bench for axi_slave_burst_mem (default parameters, DEPTH=256, 32-bit data).
module tb_axi_slave_burst_mem;

  logic        ACLK, ARESETn;
  logic [3:0]  AWID, BID, ARID, RID;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_data [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  logic [3:0]  rd_id   [16];

  axi_slave_burst_mem dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- channel drivers ----------------
  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    @(negedge ACLK);
    AWID = id; AWADDR = addr; AWLEN = len; AWBURST = burst; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!AWREADY) begin
      checks++; errors++;
      $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
    end
    @(posedge ACLK); #1 AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n;
    @(negedge ACLK);
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    n = 0;
    while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!WREADY) begin
      checks++; errors++;
      $display("FAIL w_timeout: WREADY=%b required 1", WREADY);
    end
    @(posedge ACLK); #1 WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic b_recv(output logic [1:0] resp, output logic [3:0] id);
    int n;
    @(negedge ACLK);
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    if (!BVALID) begin
      checks++; errors++;
      $display("FAIL b_timeout: BVALID=%b required 1", BVALID);
    end
    resp = BVALID ? BRESP : 2'bxx;
    id   = BID;
    @(posedge ACLK); #1 BREADY = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [3:0] strb,
                             output logic [1:0] resp, output logic [3:0] bid);
    aw_send(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) w_send(wr_data[i], strb, (i == int'(len)));
    b_recv(resp, bid);
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] burst);
    int n;
    @(negedge ACLK);
    ARID = id; ARADDR = addr; ARLEN = len; ARBURST = burst; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!ARREADY) begin
      checks++; errors++;
      $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY);
    end
    @(posedge ACLK); #1 ARVALID = 1'b0;
  endtask

  task automatic r_recv(input int beat);
    int n;
    @(negedge ACLK);
    RREADY = 1'b1;
    n = 0;
    while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
    if (!RVALID) begin
      checks++; errors++;
      $display("FAIL r_timeout: RVALID=%b required 1", RVALID);
    end
    rd_data[beat] = RDATA; rd_resp[beat] = RVALID ? RRESP : 2'bxx;
    rd_last[beat] = RLAST; rd_id[beat] = RID;
    @(posedge ACLK); #1 RREADY = 1'b0;
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [1:0] burst);
    ar_send(id, addr, len, burst);
    for (int i = 0; i <= int'(len); i++) r_recv(i);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARBURST = '0; ARVALID = 1'b0; RREADY = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0) begin
      errors++;
      $display("FAIL reset_handshakes: got %b required 000000",
               {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST});
    end
    checks++;
    if ({BID, BRESP, RID, RRESP, RDATA} !== 44'h0) begin
      errors++;
      $display("FAIL reset_payload: BID=%h BRESP=%h RID=%h RRESP=%h RDATA=%h required all 0",
               BID, BRESP, RID, RRESP, RDATA);
    end
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    checks++;
    if ({AWREADY, ARREADY} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_ready: AWREADY=%b ARREADY=%b required 1 1", AWREADY, ARREADY);
    end
  endtask

  task automatic test_incr();
    logic [1:0] resp;
    logic [3:0] bid;
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hA0 + 32'(i);
    write_burst(4'h3, 32'h10, 8'd3, 2'b01, 4'hF, resp, bid);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL incr_bresp: got %b required 00", resp); end
    checks++;
    if (bid !== 4'h3) begin errors++; $display("FAIL incr_bid: got %h required 3", bid); end
    read_burst(4'h9, 32'h10, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== 32'hA0 + 32'(i) || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)
          || rd_id[i] !== 4'h9) begin
        errors++;
        $display("FAIL incr_rbeat[%0d]: data=%h resp=%b last=%b id=%h required data=%h resp=00 last=%b id=9",
                 i, rd_data[i], rd_resp[i], rd_last[i], rd_id[i], 32'hA0 + 32'(i), (i == 3));
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [3:0] bid;
    wr_data[0] = 32'h11223344;
    write_burst(4'h1, 32'h0, 8'd0, 2'b01, 4'hF, resp, bid);
    wr_data[0] = 32'hFFFFFFFF;
    write_burst(4'h1, 32'h0, 8'd0, 2'b01, 4'h2, resp, bid);
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL strobe_bresp: got %b required 00", resp); end
    read_burst(4'h1, 32'h0, 8'd0, 2'b01);
    checks++;
    if (rd_data[0] !== 32'h1122FF44 || rd_last[0] !== 1'b1) begin
      errors++;
      $display("FAIL strobe_rdata: got %h last=%b required 1122ff44 last=1", rd_data[0], rd_last[0]);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_d [4];
    logic [1:0]  exp_r;
`ifdef AXI_SLV_WRAP_EN
    exp_d = '{32'hA2, 32'hA3, 32'hA0, 32'hA1};
    exp_r = 2'b00;
`else
    exp_d = '{32'h0, 32'h0, 32'h0, 32'h0};
    exp_r = 2'b10;
`endif
    read_burst(4'h4, 32'h18, 8'd3, 2'b10);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== exp_d[i] || rd_resp[i] !== exp_r || rd_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL wrap_rbeat[%0d]: data=%h resp=%b last=%b required data=%h resp=%b last=%b",
                 i, rd_data[i], rd_resp[i], rd_last[i], exp_d[i], exp_r, (i == 3));
      end
    end
  endtask

  task automatic test_illegal();
    logic [1:0] resp;
    logic [3:0] bid;
    wr_data[0] = 32'h55;
    write_burst(4'h6, 32'h200, 8'd0, 2'b11, 4'hF, resp, bid);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL illegal_burst_bresp: got %b required 10", resp); end
    // WLAST on the first of two beats disagrees with AWLEN
    aw_send(4'h7, 32'h300, 8'd1, 2'b01);
    w_send(32'hE0, 4'hF, 1'b1);
    w_send(32'hE1, 4'hF, 1'b1);
    b_recv(resp, bid);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL wlast_bresp: got %b required 10", resp); end
  endtask

  task automatic test_boundary();
    logic [1:0] resp;
    logic [3:0] bid;
    wr_data[0] = 32'hB0; wr_data[1] = 32'hB1; wr_data[2] = 32'hB2; wr_data[3] = 32'hB3;
    write_burst(4'h2, 32'h3F8, 8'd3, 2'b01, 4'hF, resp, bid);
    checks++;
    if (resp !== 2'b10) begin errors++; $display("FAIL boundary_bresp: got %b required 10", resp); end
    read_burst(4'h2, 32'h3F8, 8'd3, 2'b01);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== ((i < 2) ? 32'hB0 + 32'(i) : 32'h0) ||
          rd_resp[i] !== ((i < 2) ? 2'b00 : 2'b10) || rd_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL boundary_rbeat[%0d]: data=%h resp=%b last=%b required data=%h resp=%b last=%b",
                 i, rd_data[i], rd_resp[i], rd_last[i], (i < 2) ? 32'hB0 + 32'(i) : 32'h0,
                 (i < 2) ? 2'b00 : 2'b10, (i == 3));
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [1:0] resp;
    logic [3:0] bid;
    wr_data[0] = 32'hD0; wr_data[1] = 32'hD1;
    fork
      begin
        ar_send(4'h5, 32'h10, 8'd3, 2'b01);
        r_recv(0);
        repeat (5) begin
          @(negedge ACLK);
          checks++;
          if (RVALID !== 1'b1 || RDATA !== 32'hA1 || RLAST !== 1'b0 || RRESP !== 2'b00) begin
            errors++;
            $display("FAIL stall_hold: RVALID=%b RDATA=%h RLAST=%b RRESP=%b required 1 a1 0 00",
                     RVALID, RDATA, RLAST, RRESP);
          end
        end
        for (int i = 1; i < 4; i++) r_recv(i);
      end
      begin
        write_burst(4'hC, 32'h50, 8'd1, 2'b01, 4'hF, resp, bid);
      end
    join
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_data[i] !== 32'hA0 + 32'(i) || rd_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL stall_rbeat[%0d]: data=%h last=%b required data=%h last=%b",
                 i, rd_data[i], rd_last[i], 32'hA0 + 32'(i), (i == 3));
      end
    end
    checks++;
    if (resp !== 2'b00 || bid !== 4'hC) begin
      errors++;
      $display("FAIL concurrent_b: BRESP=%b BID=%h required 00 c", resp, bid);
    end
    read_burst(4'h0, 32'h50, 8'd1, 2'b01);
    checks++;
    if (rd_data[0] !== 32'hD0 || rd_data[1] !== 32'hD1) begin
      errors++;
      $display("FAIL concurrent_data: got %h %h required d0 d1", rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_reset_mid_burst();
    aw_send(4'h3, 32'h100, 8'd7, 2'b01);
    w_send(32'hC0, 4'hF, 1'b0);
    w_send(32'hC1, 4'hF, 1'b0);
    @(negedge ACLK);
    WDATA = 32'hC2; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
    ARESETn = 1'b0;
    #1;
    checks++;
    if ({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_handshakes: got %b required 000000",
               {AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST});
    end
    @(negedge ACLK);
    ARESETn = 1'b1; WVALID = 1'b0;
    @(posedge ACLK); #1;
    checks++;
    if ({AWREADY, ARREADY, WREADY, BVALID} !== 4'b1100) begin
      errors++;
      $display("FAIL midreset_release: AWREADY=%b ARREADY=%b WREADY=%b BVALID=%b required 1 1 0 0",
               AWREADY, ARREADY, WREADY, BVALID);
    end
    read_burst(4'h8, 32'h100, 8'd1, 2'b01);
    checks++;
    if (rd_data[0] !== 32'hC0 || rd_data[1] !== 32'hC1 || rd_resp[0] !== 2'b00) begin
      errors++;
      $display("FAIL midreset_retained: got %h %h resp=%b required c0 c1 resp=00",
               rd_data[0], rd_data[1], rd_resp[0]);
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_strobe();
    test_wrap();
    test_illegal();
    test_boundary();
    test_back_pressure();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_slave_burst_mem.md
AXI_SLAVE_BURST_MEM -- requirements
Module: axi_slave_burst_mem

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width, one of 32/64/128.
REQ-004 SHALL have parameter DEPTH, default 256, memory size in DATA_WIDTH words, power of two.
REQ-005 SHALL have port ACLK, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port ARESETn, input, 1, reset: asynchronous, active-low.
REQ-007 SHALL have AW channel ports: AWID in ID_WIDTH; AWADDR in ADDR_WIDTH; AWLEN in 8; AWBURST in 2; AWVALID in 1; AWREADY out 1.
REQ-008 SHALL have W channel ports: WDATA in DATA_WIDTH; WSTRB in DATA_WIDTH/8; WLAST in 1; WVALID in 1; WREADY out 1.
REQ-009 SHALL have B channel ports: BID out ID_WIDTH; BRESP out 2; BVALID out 1; BREADY in 1.
REQ-010 SHALL have AR channel ports: ARID in ID_WIDTH; ARADDR in ADDR_WIDTH; ARLEN in 8; ARBURST in 2; ARVALID in 1; ARREADY out 1.
REQ-011 SHALL have R channel ports: RID out ID_WIDTH; RDATA out DATA_WIDTH; RRESP out 2; RLAST out 1; RVALID out 1; RREADY in 1.

Function
REQ-012 SHALL use word index = ADDR >> log2(DATA_WIDTH/8); index >= DEPTH is out of range.
REQ-013 SHALL run write FSM W_IDLE -> W_DATA on AW handshake, W_DATA -> W_RESP on beat AWLEN accepted, W_RESP -> W_IDLE on B handshake.
REQ-014 SHALL drive AWREADY=1 only in W_IDLE, WREADY=1 only in W_DATA, BVALID=1 only in W_RESP.
REQ-015 SHALL latch AWID/AWADDR/AWLEN/AWBURST on the AW handshake edge; BID = latched AWID.
REQ-016 SHALL write byte lane k of a W beat only when WSTRB[k]=1; other bytes unchanged.
REQ-017 SHALL set BRESP=SLVERR (2'b10) if any beat was out of range, burst illegal, or WLAST disagreed with beat count, else OKAY; out-of-range beats not written.
REQ-018 SHALL hold BVALID/BID/BRESP stable until BREADY=1.
REQ-019 SHALL run read FSM R_IDLE -> R_DATA on AR handshake, R_DATA -> R_IDLE on R handshake of beat ARLEN; ARREADY=1 only in R_IDLE.
REQ-020 SHALL present first RDATA with RVALID=1 the cycle after the AR handshake (1-cycle latency); each later beat the cycle after the previous R handshake.
REQ-021 SHALL hold RID/RDATA/RRESP/RLAST stable while RVALID=1 and RREADY=0.
REQ-022 SHALL assert RLAST only on beat ARLEN; RRESP per beat: SLVERR with RDATA=0 if out of range or burst illegal, else OKAY.
REQ-023 SHALL advance address per beat: FIXED (2'b00) unchanged; INCR (2'b01) +1 word; WRAP (2'b10) +1 word wrapping at (LEN+1)-word aligned boundary.
REQ-024 SHALL treat WRAP with LEN+1 not in {2,4,8,16}, and burst 2'b11, as illegal: no memory access, SLVERR on every beat/response.
REQ-025 SHALL let read and write channels run concurrently; same-word collision in one cycle returns pre-write data on R.
REQ-026 SHALL handle INCR bursts crossing DEPTH per beat: in-range beats OKAY, later beats SLVERR.

Reset
REQ-027 SHALL on ARESETn=0 force both FSMs to IDLE and AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST to 0, BID/BRESP/RID/RRESP/RDATA to 0.
REQ-028 SHALL abort any burst in progress on reset without response; memory contents SHALL NOT be cleared.
REQ-029 SHALL drive AWREADY=1 and ARREADY=1 the first clock edge after ARESETn deasserts.

Configuration
REQ-030 SHALL support WRAP bursts only when macro AXI_SLV_WRAP_EN is defined; otherwise AWBURST/ARBURST=2'b10 SHALL be illegal per REQ-024.

Verification
REQ-031 SHALL test INCR write AWADDR=0x10, AWLEN=3, data 0xA0..0xA3, WSTRB=0xF -> BRESP=OKAY; INCR read same -> 0xA0..0xA3, RLAST on 4th beat.
REQ-032 SHALL test byte strobes: write 0x11223344 to 0x0, then 0xFFFFFFFF with WSTRB=0x2 -> read 0x1122FF44.
REQ-033 SHALL test WRAP read ARADDR=0x18, ARLEN=3 -> words 6,7,4,5; without AXI_SLV_WRAP_EN -> 4 beats RRESP=SLVERR, RDATA=0.
REQ-034 SHALL test INCR write at word 254, AWLEN=3 (DEPTH=256) -> words 254,255 written, BRESP=SLVERR.
REQ-035 SHALL test RREADY low 5 cycles mid-burst -> RDATA/RLAST stable, no beat lost; concurrent write to other address completes.
REQ-036 SHALL test ARESETn pulse during beat 2 of AWLEN=7 write -> all valids/readies 0, AWREADY=1 next edge, earlier beats retained.
